// File: rtl/sync_fifo_param_pkg.sv
// Shared FIFO definitions: default geometry, read-mode constants and the per-cycle op type.
package sync_fifo_param_pkg;

    localparam int unsigned FIFO_DEF_DATA_WIDTH = 4;
    localparam int unsigned FIFO_DEF_ADDR_WIDTH = 3;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Accepted operations for one cycle, after gating with full/empty.
    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_op_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_param.
interface sync_fifo_param_if
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_DEF_ADDR_WIDTH
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram_dp.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, asynchronous read port.
module fifo_ram_dp #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and optional first-word-fall-through read.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FIFO_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = FIFO_DEF_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned FWFT          = FIFO_MODE_STD
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    fifo_op_t              acc_c;

    // Acceptance uses the registered flags, so a blocked op never touches state.
    always_comb begin
        acc_c    = '0;
        acc_c.wr = bus.wr_en && !full_q;
        acc_c.rd = bus.rd_en && !empty_q;
        count_d  = count_q;
        if (acc_c.wr && !acc_c.rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (!acc_c.wr && acc_c.rd) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (acc_c.wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (acc_c.rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= CNT_W'(AFULL_THRESH));
            aempty_q <= (count_d <= CNT_W'(AEMPTY_THRESH));
            // Set beats clear when both happen in the same cycle.
            if (bus.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd_en && empty_q) begin
                unf_q <= 1'b1;
            end else if (bus.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (acc_c.wr),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; rd_en acts as a pop.
        assign bus.rd_data  = ram_rdata;
        assign bus.rd_valid = !empty_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= acc_c.rd;
                if (acc_c.rd) rd_data_q <= ram_rdata;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-read and one FWFT instance.
module tb_sync_fifo_param;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    sync_fifo_param_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) bus_s ();
    sync_fifo_param_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) bus_f ();

    sync_fifo_param #(
        .DATA_WIDTH(4), .ADDR_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    sync_fifo_param #(
        .DATA_WIDTH(4), .ADDR_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus_f.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] q[$];
        logic [3:0] wval;
        logic [3:0] exp_d;
        int         mcnt;
        logic       w;
        logic       r;
        logic       wa;
        logic       ra;

        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus_s.wr_en = 1'b0; bus_s.wr_data = '0; bus_s.rd_en = 1'b0; bus_s.clr_err = 1'b0;
        bus_f.wr_en = 1'b0; bus_f.wr_data = '0; bus_f.rd_en = 1'b0; bus_f.clr_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count",  32'(bus_s.count), 32'd0);
        chk("rst_empty",  32'(bus_s.empty), 32'd1);
        chk("rst_full",   32'(bus_s.full), 32'd0);
        chk("rst_aempty", 32'(bus_s.almost_empty), 32'd1);
        chk("rst_afull",  32'(bus_s.almost_full), 32'd0);
        chk("rst_rdata",  32'(bus_s.rd_data), 32'd0);
        chk("rst_rvalid", 32'(bus_s.rd_valid), 32'd0);
        chk("rst_ovf",    32'(bus_s.overflow), 32'd0);
        chk("rst_unf",    32'(bus_s.underflow), 32'd0);

        // 1: fill with 0x1..0x8, then overflow with 0x9
        for (int i = 1; i <= 8; i++) begin
            bus_s.wr_en = 1'b1; bus_s.wr_data = 4'(i);
            tick();
            chk("fill_count",  32'(bus_s.count), 32'(i));
            chk("fill_afull",  32'(bus_s.almost_full), 32'(i >= 6));
            chk("fill_aempty", 32'(bus_s.almost_empty), 32'(i <= 2));
            chk("fill_full",   32'(bus_s.full), 32'(i == 8));
            chk("fill_empty",  32'(bus_s.empty), 32'd0);
        end
        bus_s.wr_data = 4'h9;
        tick();
        bus_s.wr_en = 1'b0;
        chk("ovf_count", 32'(bus_s.count), 32'd8);
        chk("ovf_flag",  32'(bus_s.overflow), 32'd1);
        chk("ovf_full",  32'(bus_s.full), 32'd1);

        // 2: drain 8, then read while empty
        for (int i = 1; i <= 8; i++) begin
            bus_s.rd_en = 1'b1;
            tick();
            chk("drain_rvalid", 32'(bus_s.rd_valid), 32'd1);
            chk("drain_rdata",  32'(bus_s.rd_data), 32'(i));
            chk("drain_count",  32'(bus_s.count), 32'(8 - i));
        end
        chk("drain_empty", 32'(bus_s.empty), 32'd1);
        tick();
        bus_s.rd_en = 1'b0;
        chk("unf_flag",   32'(bus_s.underflow), 32'd1);
        chk("unf_rvalid", 32'(bus_s.rd_valid), 32'd0);
        chk("unf_rdata",  32'(bus_s.rd_data), 32'h8);
        tick();
        chk("idle_rvalid", 32'(bus_s.rd_valid), 32'd0);
        bus_s.clr_err = 1'b1;
        tick();
        bus_s.clr_err = 1'b0;
        chk("clr_ovf", 32'(bus_s.overflow), 32'd0);
        chk("clr_unf", 32'(bus_s.underflow), 32'd0);

        // 3: simultaneous write/read at count 4, then at full
        for (int i = 0; i < 4; i++) begin
            bus_s.wr_en = 1'b1; bus_s.wr_data = 4'(4'hA + i);
            tick();
        end
        chk("sim_count4", 32'(bus_s.count), 32'd4);
        bus_s.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_s.wr_data = 4'(i + 1);
            tick();
            chk("sim_count", 32'(bus_s.count), 32'd4);
            chk("sim_rdata", 32'(bus_s.rd_data), 32'(4'hA + i));
        end
        bus_s.rd_en = 1'b0;
        for (int i = 4; i < 8; i++) begin
            bus_s.wr_data = 4'(i);
            tick();
        end
        chk("sim_full", 32'(bus_s.full), 32'd1);
        bus_s.rd_en = 1'b1; bus_s.wr_data = 4'hF;
        tick();
        bus_s.wr_en = 1'b0;
        chk("simfull_count", 32'(bus_s.count), 32'd7);
        chk("simfull_ovf",   32'(bus_s.overflow), 32'd1);
        chk("simfull_rdata", 32'(bus_s.rd_data), 32'hD);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("simtail_rdata", 32'(bus_s.rd_data), 32'(i));
        end
        bus_s.rd_en = 1'b0;
        chk("simtail_empty", 32'(bus_s.empty), 32'd1);
        bus_s.clr_err = 1'b1;
        tick();
        bus_s.clr_err = 1'b0;

        // 4: wrap-around against a queue model
        q.delete();
        mcnt = 0;
        wval = 4'h8;
        for (int k = 0; k < 20; k++) begin
            w  = (k < 8) || (k == 9) || (k == 17) || (k == 18);
            r  = (k >= 8 && k <= 16) || (k >= 18);
            wa = w && (mcnt < 8);
            ra = r && (mcnt > 0);
            bus_s.wr_en = w; bus_s.wr_data = wval; bus_s.rd_en = r;
            exp_d = 4'h0;
            if (ra) exp_d = q.pop_front();
            if (wa) q.push_back(wval);
            if (w) wval = wval + 4'h1;
            mcnt = q.size();
            tick();
            chk("wrap_count",  32'(bus_s.count), 32'(mcnt));
            chk("wrap_rvalid", 32'(bus_s.rd_valid), 32'(ra));
            if (ra) chk("wrap_rdata", 32'(bus_s.rd_data), 32'(exp_d));
        end
        bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0;
        chk("wrap_empty", 32'(bus_s.empty), 32'd1);

        // 5: first-word-fall-through instance
        chk("fwft_rst_empty",  32'(bus_f.empty), 32'd1);
        chk("fwft_rst_rvalid", 32'(bus_f.rd_valid), 32'd0);
        bus_f.wr_en = 1'b1; bus_f.wr_data = 4'hA;
        tick();
        bus_f.wr_en = 1'b0;
        chk("fwft_empty",  32'(bus_f.empty), 32'd0);
        chk("fwft_rvalid", 32'(bus_f.rd_valid), 32'd1);
        chk("fwft_rdata",  32'(bus_f.rd_data), 32'hA);
        tick();
        chk("fwft_hold", 32'(bus_f.rd_data), 32'hA);
        bus_f.rd_en = 1'b1;
        tick();
        bus_f.rd_en = 1'b0;
        chk("fwft_pop_empty",  32'(bus_f.empty), 32'd1);
        chk("fwft_pop_rvalid", 32'(bus_f.rd_valid), 32'd0);
        bus_f.wr_en = 1'b1; bus_f.wr_data = 4'hB;
        tick();
        bus_f.wr_data = 4'hC;
        tick();
        bus_f.wr_en = 1'b0;
        chk("fwft_head_b", 32'(bus_f.rd_data), 32'hB);
        bus_f.rd_en = 1'b1;
        tick();
        bus_f.rd_en = 1'b0;
        chk("fwft_head_c", 32'(bus_f.rd_data), 32'hC);
        chk("fwft_valid_c", 32'(bus_f.rd_valid), 32'd1);

        // 6: reset mid-operation, then clear colliding with a new overflow
        bus_s.wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_s.wr_data = 4'(i);
            tick();
        end
        bus_s.wr_en = 1'b0;
        bus_s.rd_en = 1'b1;
        tick(); tick(); tick();
        bus_s.rd_en = 1'b0;
        chk("pre_rst_count", 32'(bus_s.count), 32'd5);
        chk("pre_rst_ovf",   32'(bus_s.overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count",  32'(bus_s.count), 32'd0);
        chk("mid_rst_empty",  32'(bus_s.empty), 32'd1);
        chk("mid_rst_ovf",    32'(bus_s.overflow), 32'd0);
        chk("mid_rst_rvalid", 32'(bus_s.rd_valid), 32'd0);
        bus_s.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_s.wr_data = 4'(i);
            tick();
        end
        bus_s.clr_err = 1'b1;
        tick();
        bus_s.wr_en = 1'b0;
        chk("setwins_ovf", 32'(bus_s.overflow), 32'd1);
        tick();
        bus_s.clr_err = 1'b0;
        chk("clr_after_ovf", 32'(bus_s.overflow), 32'd0);
        chk("clr_after_cnt", 32'(bus_s.count), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
